// File: rtl/jcs_bus_sequencer.sv
// Micro-sequencer for the shared 8-bit jcs bus: turns MOVE/ALU commands into
// timed enable-select / set-select / set-strobe sequences for the 4x16 decoders.
module jcs_bus_sequencer #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned HOLD   = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_kind,
  input  logic [3:0] cmd_src_a,
  input  logic [3:0] cmd_src_b,
  input  logic [3:0] cmd_dst,
  input  logic [2:0] cmd_op,
  output logic [3:0] ena_sel,
  output logic [3:0] set_sel,
  output logic       set_stb,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] xfer_cnt
);

  localparam int unsigned UNIT_W  = 4;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 8;

  localparam logic [UNIT_W-1:0] U_NONE = 4'd0;
  localparam logic [UNIT_W-1:0] U_DATA = 4'd1;
  localparam logic [UNIT_W-1:0] U_R0   = 4'd2;
  localparam logic [UNIT_W-1:0] U_R1   = 4'd3;
  localparam logic [UNIT_W-1:0] U_R2   = 4'd4;
  localparam logic [UNIT_W-1:0] U_R3   = 4'd5;
  localparam logic [UNIT_W-1:0] U_TMP  = 4'd6;
  localparam logic [UNIT_W-1:0] U_ACC  = 4'd7;
  localparam logic [UNIT_W-1:0] U_MAR  = 4'd8;
  localparam logic [UNIT_W-1:0] U_RAM  = 4'd9;

  localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE - 1);
  localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'(HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_STROBE,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t              state;
  logic [PHASE_W-1:0]  phase_cnt;
  logic [IDX_W-1:0]    xfer_idx;
  logic                kind_q;
  logic [UNIT_W-1:0]   src_b_q;
  logic [UNIT_W-1:0]   dst_q;

  logic cmd_legal_c;
  logic last_xfer_c;

  function automatic logic is_src(input logic [UNIT_W-1:0] u);
    return u inside {U_DATA, U_R0, U_R1, U_R2, U_R3, U_ACC, U_RAM};
  endfunction

  function automatic logic is_dst(input logic [UNIT_W-1:0] u);
    return u inside {U_R0, U_R1, U_R2, U_R3, U_TMP, U_ACC, U_MAR, U_RAM};
  endfunction

  // Command legality on the offered fields; ALU adds the TMP/ACC routing limits.
  always_comb begin
    cmd_legal_c = is_src(cmd_src_a) && is_dst(cmd_dst);
    if (cmd_kind)
      cmd_legal_c = cmd_legal_c && is_src(cmd_src_b) &&
                    (cmd_src_b != U_ACC) && (cmd_dst != U_TMP);
  end

  // MOVE ends after transfer 0; ALU after transfer 1 when the result stays in ACC.
  always_comb begin
    last_xfer_c = !kind_q || (xfer_idx == IDX_W'(2)) ||
                  ((xfer_idx == IDX_W'(1)) && (dst_q == U_ACC));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      xfer_idx  <= '0;
      kind_q    <= 1'b0;
      src_b_q   <= U_NONE;
      dst_q     <= U_NONE;
      cmd_ready <= 1'b1;
      ena_sel   <= U_NONE;
      set_sel   <= U_NONE;
      set_stb   <= 1'b0;
      alu_op    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (cmd_valid) begin
            if (cmd_legal_c) begin
              kind_q    <= cmd_kind;
              src_b_q   <= cmd_src_b;
              dst_q     <= cmd_dst;
              xfer_idx  <= '0;
              phase_cnt <= '0;
              ena_sel   <= cmd_src_a;
              set_sel   <= cmd_kind ? U_TMP : cmd_dst;
              alu_op    <= cmd_kind ? cmd_op : OP_W'(0);
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= ST_SETTLE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (phase_cnt == SETTLE_LAST) begin
            set_stb <= 1'b1;
            state   <= ST_STROBE;
          end else begin
            phase_cnt <= phase_cnt + PHASE_W'(1);
          end
        end
        ST_STROBE: begin
          set_stb   <= 1'b0;
          phase_cnt <= '0;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            ena_sel <= U_NONE;
            set_sel <= U_NONE;
            if (last_xfer_c) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              alu_op    <= '0;
              xfer_cnt  <= xfer_cnt + CNT_W'(1);
            end else begin
              state <= ST_GAP;
            end
          end else begin
            phase_cnt <= phase_cnt + PHASE_W'(1);
          end
        end
        ST_GAP: begin
          // Transfer 1 is src_b->ACC, transfer 2 is ACC->dst.
          xfer_idx  <= xfer_idx + IDX_W'(1);
          phase_cnt <= '0;
          ena_sel   <= (xfer_idx == '0) ? src_b_q : U_ACC;
          set_sel   <= (xfer_idx == '0) ? U_ACC : dst_q;
          state     <= ST_SETTLE;
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          ena_sel   <= U_NONE;
          set_sel   <= U_NONE;
          set_stb   <= 1'b0;
          alu_op    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jcs_bus_sequencer.sv
// Bench for jcs_bus_sequencer: directed and random commands checked cycle by cycle
// against a transfer-list model of the expected bus trace.
module tb_jcs_bus_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       v1, v2;
  logic       kind;
  logic [3:0] a, b, d;
  logic [2:0] op;

  logic       r1, st1, bz1, dn1, er1, r2, st2, bz2, dn2, er2;
  logic [3:0] e1, s1, e2, s2;
  logic [2:0] ao1, ao2;
  logic [7:0] xc1, xc2;

  jcs_bus_sequencer #(.SETTLE(1), .HOLD(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .cmd_valid(v1), .cmd_ready(r1), .cmd_kind(kind),
    .cmd_src_a(a), .cmd_src_b(b), .cmd_dst(d), .cmd_op(op),
    .ena_sel(e1), .set_sel(s1), .set_stb(st1), .alu_op(ao1),
    .busy(bz1), .done(dn1), .err(er1), .xfer_cnt(xc1));

  jcs_bus_sequencer #(.SETTLE(3), .HOLD(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .cmd_valid(v2), .cmd_ready(r2), .cmd_kind(kind),
    .cmd_src_a(a), .cmd_src_b(b), .cmd_dst(d), .cmd_op(op),
    .ena_sel(e2), .set_sel(s2), .set_stb(st2), .alu_op(ao2),
    .busy(bz2), .done(dn2), .err(er2), .xfer_cnt(xc2));

  int checks = 0;
  int errors = 0;
  bit use2 = 1'b0;
  logic [7:0] mcnt [2];
  logic [23:0] exp_q [$];
  logic [3:0] lsrc [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd9};
  logic [3:0] ldst [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

  // Observation vector of the DUT currently under test.
  logic [23:0] obs_c;
  always_comb
    obs_c = use2 ? {e2, s2, st2, bz2, dn2, r2, er2, ao2, xc2}
                 : {e1, s1, st1, bz1, dn1, r1, er1, ao1, xc1};

  function automatic logic [23:0] pk(input logic [3:0] en, input logic [3:0] se,
                                     input logic stb, input logic bz, input logic dn,
                                     input logic rd, input logic er,
                                     input logic [2:0] o, input logic [7:0] c);
    return {en, se, stb, bz, dn, rd, er, o, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%06h expected=%06h", tag, o, e);
    end
  endtask

  function automatic bit legal(input logic k, input logic [3:0] sa, input logic [3:0] sb,
                               input logic [3:0] ds);
    bit src_ok, dst_ok, ok;
    src_ok = (sa == 1) || (sa >= 2 && sa <= 5) || (sa == 7) || (sa == 9);
    dst_ok = (ds >= 2 && ds <= 9);
    ok = src_ok && dst_ok;
    if (k)
      ok = ok && ((sb >= 1 && sb <= 5) || sb == 9) && (ds != 6);
    return ok;
  endfunction

  // Expected per-cycle trace after accept, built from the list of bus transfers.
  task automatic build(input logic k, input logic [3:0] sa, input logic [3:0] sb,
                       input logic [3:0] ds, input logic [2:0] o, input bit tail);
    logic [3:0] srcs [$];
    logic [3:0] dsts [$];
    int st, hd;
    logic [2:0] aop;
    logic [7:0] c;
    st = use2 ? 3 : 1;
    hd = use2 ? 2 : 1;
    c  = mcnt[use2];
    if (!legal(k, sa, sb, ds)) begin
      exp_q.push_back(pk(0, 0, 0, 0, 0, 1, 1, 0, c));
    end else begin
      if (!k) begin
        srcs.push_back(sa); dsts.push_back(ds);
      end else begin
        srcs.push_back(sa); dsts.push_back(4'd6);
        srcs.push_back(sb); dsts.push_back(4'd7);
        if (ds != 4'd7) begin
          srcs.push_back(4'd7); dsts.push_back(ds);
        end
      end
      aop = k ? o : 3'd0;
      for (int t = 0; t < srcs.size(); t++) begin
        if (t > 0) exp_q.push_back(pk(0, 0, 0, 1, 0, 0, 0, aop, c));
        for (int s = 0; s < st; s++) exp_q.push_back(pk(srcs[t], dsts[t], 0, 1, 0, 0, 0, aop, c));
        exp_q.push_back(pk(srcs[t], dsts[t], 1, 1, 0, 0, 0, aop, c));
        for (int h = 0; h < hd; h++) exp_q.push_back(pk(srcs[t], dsts[t], 0, 1, 0, 0, 0, aop, c));
      end
      c = c + 8'd1;
      mcnt[use2] = c;
      exp_q.push_back(pk(0, 0, 0, 0, 1, 1, 0, 0, c));
    end
    if (tail) exp_q.push_back(pk(0, 0, 0, 0, 0, 1, 0, 0, c));
  endtask

  task automatic scramble();
    kind = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
    d = 4'($urandom); op = 3'($urandom);
  endtask

  task automatic accept(input logic k, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] ds, input logic [2:0] o);
    @(negedge CLK);
    kind = k; a = sa; b = sb; d = ds; op = o;
    if (use2) v2 = 1'b1; else v1 = 1'b1;
    @(posedge CLK);
    #1;
    v1 = 1'b0; v2 = 1'b0;
    scramble();
  endtask

  task automatic drain_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk($sformatf("%s_c%0d", tag, i + 1), obs_c, exp_q.pop_front());
    end
  endtask

  task automatic run(input string tag, input logic k, input logic [3:0] sa,
                     input logic [3:0] sb, input logic [3:0] ds, input logic [2:0] o);
    build(k, sa, sb, ds, o, 1'b1);
    accept(k, sa, sb, ds, o);
    drain_n(tag, exp_q.size());
  endtask

  initial begin
    logic k;
    logic [3:0] sa, sb, ds;
    RST = 1'b1; v1 = 1'b0; v2 = 1'b0;
    kind = 1'b0; a = '0; b = '0; d = '0; op = '0;
    mcnt[0] = '0; mcnt[1] = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_dut1", obs_c, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    use2 = 1'b1;
    chk("reset_dut2", obs_c, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    use2 = 1'b0;
    RST = 1'b0;

    run("move_data_r2", 0, 4'd1, 4'd0, 4'd4, 3'd0);
    run("alu_r0_r1_r3", 1, 4'd2, 4'd3, 4'd5, 3'b010);
    run("alu_dst_acc", 1, 4'd4, 4'd1, 4'd7, 3'd5);
    run("move_same", 0, 4'd3, 4'd0, 4'd3, 3'd0);
    run("ill_src_mar", 0, 4'd8, 4'd0, 4'd2, 3'd0);
    run("ill_dst_data", 0, 4'd2, 4'd0, 4'd1, 3'd0);
    run("ill_alu_srcb_acc", 1, 4'd2, 4'd7, 4'd3, 3'd1);
    run("ill_code12", 0, 4'd12, 4'd0, 4'd2, 3'd0);
    run("ill_alu_dst_tmp", 1, 4'd2, 4'd3, 4'd6, 3'd1);

    // Back-to-back MOVEs with cmd_valid held; fields change right after the first accept.
    build(0, 4'd5, 4'd0, 4'd8, 3'd0, 1'b0);
    build(0, 4'd9, 4'd0, 4'd2, 3'd0, 1'b1);
    @(negedge CLK);
    kind = 0; a = 4'd5; b = 4'd0; d = 4'd8; op = 3'd0; v1 = 1'b1;
    @(posedge CLK);
    #1 a = 4'd9; d = 4'd2;
    drain_n("b2b_first", 4);
    @(posedge CLK);
    #1 v1 = 1'b0;
    scramble();
    drain_n("b2b_second", exp_q.size());

    // Random commands, biased toward legal codes.
    for (int i = 0; i < 30; i++) begin
      k  = 1'($urandom);
      sa = ($urandom_range(0, 3) != 0) ? lsrc[$urandom_range(0, 6)] : 4'($urandom);
      sb = ($urandom_range(0, 3) != 0) ? lsrc[$urandom_range(0, 6)] : 4'($urandom);
      ds = ($urandom_range(0, 3) != 0) ? ldst[$urandom_range(0, 7)] : 4'($urandom);
      run($sformatf("rnd%0d", i), k, sa, sb, ds, 3'($urandom));
    end

    use2 = 1'b1;
    run("s3h2_move", 0, 4'd1, 4'd0, 4'd4, 3'd0);
    run("s3h2_alu", 1, 4'd2, 4'd3, 4'd9, 3'd6);
    for (int i = 0; i < 4; i++)
      run($sformatf("s3h2_rnd%0d", i), 1'($urandom), lsrc[$urandom_range(0, 6)],
          lsrc[$urandom_range(0, 6)], ldst[$urandom_range(0, 7)], 3'($urandom));
    use2 = 1'b0;

    // Reset during SETTLE of an ALU command: immediate reset values, no strobe afterwards.
    accept(1, 4'd2, 4'd3, 4'd5, 3'd2);
    @(negedge CLK);
    chk("rst_pre_settle", obs_c, pk(2, 6, 0, 1, 0, 0, 0, 2, mcnt[0]));
    #2 RST = 1'b1;
    #1 chk("rst_async", obs_c, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    @(negedge CLK);
    chk("rst_held", obs_c, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    RST = 1'b0;
    mcnt[0] = '0; mcnt[1] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("rst_after%0d", i), obs_c, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    end

    // 256 completed MOVEs wrap the counter back to zero.
    for (int i = 0; i < 256; i++)
      run($sformatf("wrap%0d", i), 0, lsrc[$urandom_range(0, 6)], 4'd0,
          ldst[$urandom_range(0, 7)], 3'd0);
    chk("wrap_cnt", {24'd0, xc1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
